// File: rtl/axi4_lite_mem_tester.sv
// AXI4-Lite write-then-read-back memory tester: one outstanding transaction at a time,
// selectable data pattern, sticky error flags, saturating mismatch count and first-error address.
module axi4_lite_mem_tester #(
  parameter int unsigned addr_width_p = 28,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned base_addr_p  = 0,
  parameter int unsigned num_words_p  = 256
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  output logic [addr_width_p-1:0]   awaddr_o,
  output logic [2:0]                awprot_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [data_width_p-1:0]   wdata_o,
  output logic [data_width_p/8-1:0] wstrb_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  input  logic [1:0]                bresp_i,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  output logic [addr_width_p-1:0]   araddr_o,
  output logic [2:0]                arprot_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  input  logic [data_width_p-1:0]   rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      wr_error_o,
  output logic                      rd_error_o,
  output logic [15:0]               err_count_o,
  output logic [addr_width_p-1:0]   first_err_addr_o
);

  localparam int unsigned off_lp   = $clog2(data_width_p / 8);
  localparam int unsigned idx_w_lp = (num_words_p > 1) ? $clog2(num_words_p) : 1;
  localparam logic [31:0] taps_lp  = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, DONE} state_e;

  state_e                  state_q, state_d;
  logic [idx_w_lp-1:0]     idx_q, idx_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [1:0]              mode_q, mode_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    wr_err_q, wr_err_d;
  logic                    rd_err_q, rd_err_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [addr_width_p-1:0] first_q, first_d;

  logic [addr_width_p-1:0] addr_w;
  logic [data_width_p-1:0] pattern_w;
  logic [31:0]             lfsr_step_w;
  logic                    last_w;
  logic                    capture_ok_w;
  logic                    rd_bad_w;

  assign addr_w       = addr_width_p'(base_addr_p) + (addr_width_p'(idx_q) << off_lp);
  assign lfsr_step_w  = lfsr_q[0] ? ((lfsr_q >> 1) ^ taps_lp) : (lfsr_q >> 1);
  assign last_w       = (idx_q == idx_w_lp'(num_words_p - 1));
  assign capture_ok_w = (err_cnt_q == 16'd0) && !wr_err_q;

  always_comb begin
    pattern_w = '0;
    case (mode_q)
      2'd0:    pattern_w = data_width_p'(addr_w);
      2'd1:    pattern_w = data_width_p'(idx_q);
      2'd2:    pattern_w = ~data_width_p'(addr_w);
      default: pattern_w = {(data_width_p / 32){lfsr_q}};
    endcase
  end

  assign rd_bad_w = (rresp_i != 2'b00) || (rdata_i != pattern_w);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_err_d  = wr_err_q;
    rd_err_d  = rd_err_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = WR;
          idx_d     = '0;
          lfsr_d    = 32'h1;
          mode_d    = mode_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_err_d  = 1'b0;
          rd_err_d  = 1'b0;
          err_cnt_d = '0;
          first_d   = '0;
        end
      end
      WR: begin
        // valid is held only on a channel whose handshake has not yet happened
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          if (bresp_i != 2'b00) begin
            wr_err_d = 1'b1;
            if (capture_ok_w) first_d = addr_w;
          end
          if (last_w) begin
            idx_d   = '0;
            lfsr_d  = 32'h1;
            state_d = RD;
          end else begin
            idx_d   = idx_q + 1'b1;
            lfsr_d  = lfsr_step_w;
            state_d = WR;
          end
        end
      end
      RD: begin
        if (arready_i) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid_i) begin
          if (rd_bad_w) begin
            rd_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (capture_ok_w) first_d = addr_w;
          end
          if (last_w) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            lfsr_d  = lfsr_step_w;
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lfsr_q    <= 32'h1;
      mode_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  // Handshake outputs come straight from registered state, so reset clears them at once.
  assign awaddr_o         = addr_w;
  assign araddr_o         = addr_w;
  assign wdata_o          = pattern_w;
  assign awprot_o         = 3'b000;
  assign arprot_o         = 3'b000;
  assign wstrb_o          = '1;
  assign awvalid_o        = (state_q == WR) && !aw_done_q;
  assign wvalid_o         = (state_q == WR) && !w_done_q;
  assign bready_o         = (state_q == WRESP);
  assign arvalid_o        = (state_q == RD);
  assign rready_o         = (state_q == RDATA);
  assign busy_o           = (state_q == WR) || (state_q == WRESP) || (state_q == RD) || (state_q == RDATA);
  assign done_o           = (state_q == DONE);
  assign wr_error_o       = wr_err_q;
  assign rd_error_o       = rd_err_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule
